// File: rtl/activation_writeback.sv
// Serializes one wide activation vector into 16-bit port-A BRAM writes, lane 0 first,
// most significant chunk of each lane first, at consecutive (wrapping) addresses.
module activation_writeback #(
    parameter int MAX_WORD_LENGTH = 32,
    parameter int LANES           = 2,
    parameter int ADDR_W          = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  base_addr,
    input  logic                               in_valid,
    input  logic [0:LANES*MAX_WORD_LENGTH-1]   in_data,
    output logic                               in_ready,
    output logic                               WE,
    output logic [ADDR_W-1:0]                  ADDR,
    output logic [15:0]                        DI,
    output logic                               busy,
    output logic                               done,
    output logic                               wrapped
);

    localparam int VEC_W  = LANES * MAX_WORD_LENGTH;
    localparam int CHUNKS = MAX_WORD_LENGTH / 16;
    localparam int N      = LANES * CHUNKS;
    localparam int CNT_W  = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  LAST_CHUNK = CNT_W'(N);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t             r_state, w_nextState;
    logic [0:VEC_W-1]   r_shift, w_nextShift;
    logic [CNT_W-1:0]   r_count, w_nextCount;
    logic               r_inReady, w_nextInReady;
    logic               r_we, w_nextWe;
    logic [ADDR_W-1:0]  r_addr, w_nextAddr;
    logic [15:0]        r_di, w_nextDi;
    logic               r_busy, w_nextBusy;
    logic               r_done, w_nextDone;
    logic               r_wrapped, w_nextWrapped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_count   <= '0;
            r_inReady <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_di      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_shift   <= w_nextShift;
            r_count   <= w_nextCount;
            r_inReady <= w_nextInReady;
            r_we      <= w_nextWe;
            r_addr    <= w_nextAddr;
            r_di      <= w_nextDi;
            r_busy    <= w_nextBusy;
            r_done    <= w_nextDone;
            r_wrapped <= w_nextWrapped;
        end
    end

    // r_count holds the number of chunks already issued; the shift register always
    // presents the next chunk to write in its top 16 bits.
    always_comb begin
        w_nextState   = r_state;
        w_nextShift   = r_shift;
        w_nextCount   = r_count;
        w_nextInReady = 1'b0;
        w_nextWe      = 1'b0;
        w_nextAddr    = r_addr;
        w_nextDi      = r_di;
        w_nextBusy    = 1'b0;
        w_nextDone    = 1'b0;
        w_nextWrapped = r_wrapped;
        case (r_state)
            IDLE: begin
                w_nextInReady = 1'b1;
                if (r_inReady && in_valid) begin
                    w_nextState   = WRITE;
                    w_nextShift   = in_data << 16;
                    w_nextCount   = CNT_W'(1);
                    w_nextInReady = 1'b0;
                    w_nextWe      = 1'b1;
                    w_nextBusy    = 1'b1;
                    w_nextAddr    = base_addr;
                    w_nextDi      = in_data[0:15];
                    w_nextWrapped = 1'b0;
                end
            end
            WRITE: begin
                if (r_count == LAST_CHUNK) begin
                    w_nextState = DONE;
                    w_nextDone  = 1'b1;
                end else begin
                    w_nextCount = r_count + CNT_W'(1);
                    w_nextWe    = 1'b1;
                    w_nextBusy  = 1'b1;
                    w_nextAddr  = r_addr + ADDR_W'(1);
                    w_nextDi    = r_shift[0:15];
                    w_nextShift = r_shift << 16;
                    if (r_addr == ADDR_MAX) begin
                        w_nextWrapped = 1'b1;
                    end
                end
            end
            DONE: begin
                w_nextState   = IDLE;
                w_nextInReady = 1'b1;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign in_ready = r_inReady;
    assign WE       = r_we;
    assign ADDR     = r_addr;
    assign DI       = r_di;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_activation_writeback.sv
// Scoreboard bench for activation_writeback: default 2x32-bit instance plus a 4x16-bit
// instance; expected writes are queued at stimulus time and popped by negedge monitors.
module tb_activation_writeback;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
        logic        wr;
        int          cycle;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic [0:63] in_data;
    logic        in_ready;
    logic        WE;
    logic [9:0]  ADDR;
    logic [15:0] DI;
    logic        busy;
    logic        done;
    logic        wrapped;

    logic [9:0]  v_base;
    logic        v_valid;
    logic [0:63] v_data;
    logic        v_ready;
    logic        v_we;
    logic [9:0]  v_addr;
    logic [15:0] v_di;
    logic        v_busy;
    logic        v_done;
    logic        v_wrapped;

    int   compared = 0;
    int   mismatched = 0;
    int   cycleCount = 0;
    int   acceptCycle = 0;
    int   accept2Cycle = 0;
    int   releaseCycle = 0;
    int   firstAccept = 0;
    exp_t expQ[$];
    exp_t expQ2[$];
    int   doneQ[$];
    int   doneQ2[$];
    exp_t monE;
    exp_t monE2;
    int   monD;

    activation_writeback #(.MAX_WORD_LENGTH(32), .LANES(2), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .base_addr(base_addr), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .WE(WE), .ADDR(ADDR), .DI(DI),
        .busy(busy), .done(done), .wrapped(wrapped)
    );

    activation_writeback #(.MAX_WORD_LENGTH(16), .LANES(4), .ADDR_W(10)) dutNarrow (
        .clk(clk), .reset(reset), .base_addr(v_base), .in_valid(v_valid),
        .in_data(v_data), .in_ready(v_ready), .WE(v_we), .ADDR(v_addr), .DI(v_di),
        .busy(v_busy), .done(v_done), .wrapped(v_wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushWrite(input logic [9:0] a, input logic [15:0] d, input logic w, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.wr = w;
        e.cycle = c;
        expQ.push_back(e);
    endtask

    // Drives one vector and waits (bounded) for the edge where it is accepted.
    task automatic applyStimulus(input logic [63:0] vec, input logic [9:0] base, input bit keepValid);
        bit accepted = 1'b0;
        @(negedge clk);
        in_data = vec;
        base_addr = base;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acceptCycle = cycleCount;
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept timeout: got no accept, expected accept within 50 cycles");
        end
        if (!keepValid) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drainCheck(input string tag);
        repeat (8) @(negedge clk);
        checkOutput({tag, " writes drained"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, " done drained"}, 32'(doneQ.size()), 32'd0);
    endtask

    // Cycle index k means the k-th cycle after the accepting edge.
    always @(negedge clk) begin
        if (WE === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, expected no write", ADDR, DI);
            end else begin
                monE = expQ.pop_front();
                checkOutput("write addr", 32'(ADDR), 32'(monE.addr));
                checkOutput("write data", 32'(DI), 32'(monE.data));
                checkOutput("write wrapped", 32'(wrapped), 32'(monE.wr));
                checkOutput("write busy", 32'(busy), 32'd1);
                checkOutput("write cycle", 32'(cycleCount - acceptCycle + 1), 32'(monE.cycle));
            end
        end
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected done: got done=1, expected done=0");
            end else begin
                monD = doneQ.pop_front();
                checkOutput("done cycle", 32'(cycleCount - acceptCycle + 1), 32'(monD));
                checkOutput("in_ready during done", 32'(in_ready), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (v_we === 1'b1) begin
            if (expQ2.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL narrow unexpected write: got addr 0x%0h data 0x%0h, expected no write", v_addr, v_di);
            end else begin
                monE2 = expQ2.pop_front();
                checkOutput("narrow write addr", 32'(v_addr), 32'(monE2.addr));
                checkOutput("narrow write data", 32'(v_di), 32'(monE2.data));
                checkOutput("narrow write cycle", 32'(cycleCount - accept2Cycle + 1), 32'(monE2.cycle));
            end
        end
        if (v_done === 1'b1) begin
            if (doneQ2.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL narrow unexpected done: got done=1, expected done=0");
            end else begin
                checkOutput("narrow done cycle", 32'(cycleCount - accept2Cycle + 1), 32'(doneQ2.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        base_addr = '0;
        v_valid = 1'b0;
        v_data = '0;
        v_base = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset WE", 32'(WE), 32'd0);
        checkOutput("reset ADDR", 32'(ADDR), 32'd0);
        checkOutput("reset DI", 32'(DI), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset wrapped", 32'(wrapped), 32'd0);

        $display("[TB] basic vector, valid already high at reset release");
        pushWrite(10'h010, 16'h1234, 1'b0, 1);
        pushWrite(10'h011, 16'h5678, 1'b0, 2);
        pushWrite(10'h012, 16'h9ABC, 1'b0, 3);
        pushWrite(10'h013, 16'hDEF0, 1'b0, 4);
        doneQ.push_back(5);
        in_data = 64'h12345678_9ABCDEF0;
        base_addr = 10'h010;
        in_valid = 1'b1;
        reset = 1'b1;
        releaseCycle = cycleCount;
        applyStimulus(64'h12345678_9ABCDEF0, 10'h010, 1'b0);
        checkOutput("accept edges after release", 32'(acceptCycle - releaseCycle), 32'd2);
        drainCheck("basic");
        checkOutput("idle in_ready", 32'(in_ready), 32'd1);

        $display("[TB] address wrap");
        pushWrite(10'h3FE, 16'h1234, 1'b0, 1);
        pushWrite(10'h3FF, 16'h5678, 1'b0, 2);
        pushWrite(10'h000, 16'h9ABC, 1'b1, 3);
        pushWrite(10'h001, 16'hDEF0, 1'b1, 4);
        doneQ.push_back(5);
        applyStimulus(64'h12345678_9ABCDEF0, 10'h3FE, 1'b0);
        drainCheck("wrap");
        checkOutput("wrapped sticky after vector", 32'(wrapped), 32'd1);

        $display("[TB] in_valid pulsed while writing");
        pushWrite(10'h010, 16'h1234, 1'b0, 1);
        pushWrite(10'h011, 16'h5678, 1'b0, 2);
        pushWrite(10'h012, 16'h9ABC, 1'b0, 3);
        pushWrite(10'h013, 16'hDEF0, 1'b0, 4);
        doneQ.push_back(5);
        applyStimulus(64'h12345678_9ABCDEF0, 10'h010, 1'b0);
        @(negedge clk);
        in_data = 64'hFFFF0000_FFFF0000;
        base_addr = 10'h200;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        drainCheck("ignored");
        checkOutput("ignored idle busy", 32'(busy), 32'd0);
        checkOutput("ignored idle in_ready", 32'(in_ready), 32'd1);

        $display("[TB] back-to-back vectors");
        pushWrite(10'h100, 16'h1234, 1'b0, 1);
        pushWrite(10'h101, 16'h5678, 1'b0, 2);
        pushWrite(10'h102, 16'h9ABC, 1'b0, 3);
        pushWrite(10'h103, 16'hDEF0, 1'b0, 4);
        doneQ.push_back(5);
        pushWrite(10'h120, 16'hCAFE, 1'b0, 1);
        pushWrite(10'h121, 16'hBABE, 1'b0, 2);
        pushWrite(10'h122, 16'h0BAD, 1'b0, 3);
        pushWrite(10'h123, 16'hF00D, 1'b0, 4);
        doneQ.push_back(5);
        applyStimulus(64'h12345678_9ABCDEF0, 10'h100, 1'b1);
        firstAccept = acceptCycle;
        applyStimulus(64'hCAFEBABE_0BADF00D, 10'h120, 1'b0);
        checkOutput("back-to-back accept spacing", 32'(acceptCycle - firstAccept), 32'd6);
        drainCheck("back-to-back");

        $display("[TB] reset during a vector");
        pushWrite(10'h050, 16'h1234, 1'b0, 1);
        applyStimulus(64'h12345678_9ABCDEF0, 10'h050, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid reset WE", 32'(WE), 32'd0);
        checkOutput("mid reset ADDR", 32'(ADDR), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("in_ready after release", 32'(in_ready), 32'd1);
        checkOutput("no done after reset", 32'(done), 32'd0);
        drainCheck("mid reset");

        $display("[TB] narrow instance, four 16-bit lanes");
        begin
            exp_t e;
            bit accepted = 1'b0;
            logic [15:0] lanes [4];
            lanes[0] = 16'hAAAA;
            lanes[1] = 16'hBBBB;
            lanes[2] = 16'hCCCC;
            lanes[3] = 16'hDDDD;
            for (int k = 0; k < 4; k++) begin
                e.addr = 10'(k);
                e.data = lanes[k];
                e.wr = 1'b0;
                e.cycle = k + 1;
                expQ2.push_back(e);
            end
            doneQ2.push_back(5);
            @(negedge clk);
            v_data = 64'hAAAABBBB_CCCCDDDD;
            v_base = 10'h000;
            v_valid = 1'b1;
            for (int i = 0; i < 50 && !accepted; i++) begin
                if (v_ready === 1'b1) begin
                    @(posedge clk);
                    #1;
                    accept2Cycle = cycleCount;
                    accepted = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
            if (!accepted) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL narrow accept timeout: got no accept, expected accept within 50 cycles");
            end
            @(negedge clk);
            v_valid = 1'b0;
            repeat (8) @(negedge clk);
            checkOutput("narrow writes drained", 32'(expQ2.size()), 32'd0);
            checkOutput("narrow done drained", 32'(doneQ2.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/activation_writeback.md
# activation_writeback

Serializes one wide activation result vector into the 16-bit port-A write interface of the tile data BRAM. It sits after the sigmoid/tanh activation arrays: those produce one word per output lane in parallel, and the BRAM accepts one 16-bit write per cycle. It is the writer side of the DIA/ADDRA/WEA path that the array top reads from, so layer outputs can land in memory as the next layer's operands.

## Interface
Parameters:
- MAX_WORD_LENGTH, 32, bits per lane word; must be a multiple of 16.
- LANES, 2, lanes per vector (PE_H*ARRAY_DIM*TILE_DIM in the integration).
- ADDR_W, 10, BRAM address width.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  reset, asynchronous, active-low.
- base_addr  input  ADDR_W  first write address; sampled only when a vector is accepted.
- in_valid  input  1  activation vector valid (the Ready_Sig/Ready_Tanh lane-0 qualifier).
- in_data  input  [0:LANES*MAX_WORD_LENGTH-1]  vector, big-endian bit order; lane k occupies bits [k*MAX_WORD_LENGTH : (k+1)*MAX_WORD_LENGTH-1].
- in_ready  output  1  block can accept a vector.
- WE  output  1  BRAM write enable.
- ADDR  output  ADDR_W  BRAM write address.
- DI  output  16  BRAM write data.
- busy  output  1  a vector is being written.
- done  output  1  one-cycle pulse after the last write of a vector.
- wrapped  output  1  sticky; the address counter crossed its maximum value back to 0 during the current vector.

## Operation
- CHUNKS = MAX_WORD_LENGTH/16. N = LANES*CHUNKS writes are issued per vector.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, capture in_data into a shift register, load the address counter with base_addr, clear wrapped, and go to WRITE.
  - WRITE: one write per cycle, N consecutive cycles. After the Nth write, go to DONE.
  - DONE: done=1 and in_ready=0 for one cycle, then go to IDLE.
- Write order: lane 0 first. Within a lane, the most significant chunk (bits [0:15] of that lane) comes first. Chunk i of the vector is written to base_addr+i, modulo 2^ADDR_W.
- Wrap-around: an address increment from 2^ADDR_W-1 goes to 0 and sets wrapped. wrapped holds until the next vector is accepted.
- in_valid outside IDLE is ignored. Upstream must hold the vector until it sees in_ready=1 with in_valid=1 on the same edge.
- Arithmetic: only the modulo-2^ADDR_W address increment and a chunk counter of width ceil(log2(N+1)). No data transformation.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, WE=0, ADDR=0, DI=0, busy=0, done=0, wrapped=0, state=IDLE.
- in_ready rises on the first clk edge after reset deasserts.
- Vector accepted at edge 0:
  - WE=1 with chunk 0 during cycles 1..N (chunk i-1 in cycle i); busy=1 in the same cycles.
  - done=1 in cycle N+1.
  - in_ready=1 again in cycle N+2.
  - Throughput is one vector per N+2 cycles.
- When WE=0: ADDR and DI hold their last values.
- Reset asserted mid-vector: all outputs return to their reset values immediately. No further writes occur, and the partial vector is discarded.
- Simultaneous in_valid and reset deassertion on the same edge: the vector is not accepted, because in_ready is still 0.

## Test plan
- Basic vector (LANES=2, MAX_WORD_LENGTH=32): lane0=0x12345678, lane1=0x9ABCDEF0, base_addr=0x010 -> writes 0x010:0x1234, 0x011:0x5678, 0x012:0x9ABC, 0x013:0xDEF0 in cycles 1-4; done in cycle 5; wrapped=0.
- Wrap: same vector with base_addr=0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001; wrapped=1 from the write to 0x000 until the next accept.
- Ignored input: pulse in_valid with a different vector in cycles 2-5 -> no change to the writes, and no second vector starts.
- Back-to-back: in_valid held high with two vectors -> second accept occurs at cycle 6; its first write is at cycle 7; exactly 8 writes total.
- Reset mid-op: assert reset in cycle 2 -> WE=0 and ADDR=0 asynchronously; no done pulse; in_ready=1 one cycle after release.
- Width variant (MAX_WORD_LENGTH=16, LANES=4): lanes 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD, base_addr=0 -> 4 writes at addresses 0-3 in lane order; done in cycle 5.
